pll_lock_supervisor: RTL and testbench



---
 rtl/pll_lock_supervisor_pkg.sv | 15 +
 rtl/pll_lock_channel.sv | 162 ++++++++++++++++
 rtl/pll_lock_supervisor.sv | 56 +++++
 tb/tb_pll_lock_supervisor.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/pll_lock_supervisor_pkg.sv
// Shared types and constants for the PLL lock supervisor.
package pll_lock_supervisor_pkg;

    localparam int unsigned LOL_COUNT_WIDTH = 8;

    typedef enum logic [2:0] {
        IDLE,
        RESET,
        WAIT_LOCK,
        FILTER,
        GOOD,
        FAULT
    } pllsup_state_t;

endpackage

// File: rtl/pll_lock_channel.sv
// One supervised PLL: LOCKED synchroniser, lock/retry FSM, release delay and
// loss-of-lock counter. All outputs are registered.
module pll_lock_channel
    import pll_lock_supervisor_pkg::*;
#(
    parameter int unsigned RESET_PULSE_CYCLES   = 16,
    parameter int unsigned LOCK_TIMEOUT_CYCLES  = 65536,
    parameter int unsigned LOCK_FILTER_CYCLES   = 8,
    parameter int unsigned RELEASE_DELAY_CYCLES = 32,
    parameter int unsigned MAX_RETRIES          = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enable,
    input  logic                       lock_raw,
    input  logic                       fault_clear,
    output logic                       pll_rst,
    output logic                       pll_good,
    output logic                       domain_rst,
    output logic                       fault,
    output logic [LOL_COUNT_WIDTH-1:0] lol_count
);

    localparam int unsigned RST_W   = $clog2(RESET_PULSE_CYCLES + 1);
    localparam int unsigned TMO_W   = $clog2(LOCK_TIMEOUT_CYCLES + 1);
    localparam int unsigned FILT_W  = $clog2(LOCK_FILTER_CYCLES + 1);
    localparam int unsigned REL_W   = $clog2(RELEASE_DELAY_CYCLES + 1);
    localparam int unsigned RETRY_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

    pllsup_state_t      state;
    logic [1:0]         lock_meta;
    logic               lock_sync;
    logic [RST_W-1:0]   rst_cnt;
    logic [TMO_W-1:0]   timer;
    logic [FILT_W-1:0]  filt_cnt;
    logic [REL_W-1:0]   rel_cnt;
    logic [RETRY_W-1:0] retries;

    // Two-flop synchroniser for the asynchronous LOCKED pin
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_meta <= '0;
        end else begin
            lock_meta <= {lock_meta[0], lock_raw};
        end
    end

    assign lock_sync = lock_meta[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            rst_cnt    <= '0;
            timer      <= '0;
            filt_cnt   <= '0;
            rel_cnt    <= '0;
            retries    <= '0;
            lol_count  <= '0;
            pll_rst    <= 1'b1;
            pll_good   <= 1'b0;
            domain_rst <= 1'b1;
            fault      <= 1'b0;
        end else if (!enable) begin
            state      <= IDLE;
            retries    <= '0;
            pll_rst    <= 1'b1;
            pll_good   <= 1'b0;
            domain_rst <= 1'b1;
            fault      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state   <= RESET;
                    rst_cnt <= '0;
                    pll_rst <= 1'b1;
                end
                RESET: begin
                    if (rst_cnt == RST_W'(RESET_PULSE_CYCLES - 1)) begin
                        state   <= WAIT_LOCK;
                        timer   <= '0;
                        pll_rst <= 1'b0;
                    end else begin
                        rst_cnt <= rst_cnt + RST_W'(1);
                    end
                end
                WAIT_LOCK: begin
                    if (lock_sync) begin
                        // A one-cycle filter is already satisfied by this sample
                        if (LOCK_FILTER_CYCLES == 1) begin
                            state    <= GOOD;
                            retries  <= '0;
                            rel_cnt  <= '0;
                            pll_good <= 1'b1;
                        end else begin
                            state    <= FILTER;
                            filt_cnt <= FILT_W'(1);
                        end
                    end else if (timer == TMO_W'(LOCK_TIMEOUT_CYCLES - 1)) begin
                        pll_rst <= 1'b1;
                        if (retries < RETRY_W'(MAX_RETRIES)) begin
                            state   <= RESET;
                            rst_cnt <= '0;
                            retries <= retries + RETRY_W'(1);
                        end else begin
                            state <= FAULT;
                            fault <= 1'b1;
                        end
                    end else begin
                        timer <= timer + TMO_W'(1);
                    end
                end
                FILTER: begin
                    if (!lock_sync) begin
                        state <= WAIT_LOCK;
                        timer <= '0;
                    end else if (filt_cnt == FILT_W'(LOCK_FILTER_CYCLES - 1)) begin
                        state    <= GOOD;
                        retries  <= '0;
                        rel_cnt  <= '0;
                        pll_good <= 1'b1;
                    end else begin
                        filt_cnt <= filt_cnt + FILT_W'(1);
                    end
                end
                GOOD: begin
                    if (!lock_sync) begin
                        state      <= RESET;
                        rst_cnt    <= '0;
                        pll_rst    <= 1'b1;
                        pll_good   <= 1'b0;
                        domain_rst <= 1'b1;
                        if (lol_count != '1) begin
                            lol_count <= lol_count + LOL_COUNT_WIDTH'(1);
                        end
                    end else if (rel_cnt != REL_W'(RELEASE_DELAY_CYCLES)) begin
                        rel_cnt <= rel_cnt + REL_W'(1);
                        if (rel_cnt == REL_W'(RELEASE_DELAY_CYCLES - 1)) begin
                            domain_rst <= 1'b0;
                        end
                    end
                end
                FAULT: begin
                    if (fault_clear) begin
                        state   <= RESET;
                        rst_cnt <= '0;
                        retries <= '0;
                        fault   <= 1'b0;
                        pll_rst <= 1'b1;
                    end
                end
                default: begin
                    state      <= IDLE;
                    pll_rst    <= 1'b1;
                    pll_good   <= 1'b0;
                    domain_rst <= 1'b1;
                    fault      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/pll_lock_supervisor.sv
// Supervisor for the PLL/MMCM bank: one lock channel per PLL plus the
// bank-wide all_good flag and the flattened loss-of-lock counters.
module pll_lock_supervisor
    import pll_lock_supervisor_pkg::*;
#(
    parameter int unsigned NUM_PLLS             = 2,
    parameter int unsigned RESET_PULSE_CYCLES   = 16,
    parameter int unsigned LOCK_TIMEOUT_CYCLES  = 65536,
    parameter int unsigned LOCK_FILTER_CYCLES   = 8,
    parameter int unsigned RELEASE_DELAY_CYCLES = 32,
    parameter int unsigned MAX_RETRIES          = 3
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NUM_PLLS-1:0]                 pll_enable,
    input  logic [NUM_PLLS-1:0]                 pll_lock_raw,
    input  logic                                fault_clear,
    output logic [NUM_PLLS-1:0]                 pll_rst,
    output logic [NUM_PLLS-1:0]                 pll_good,
    output logic [NUM_PLLS-1:0]                 domain_rst,
    output logic [NUM_PLLS-1:0]                 fault,
    output logic [LOL_COUNT_WIDTH*NUM_PLLS-1:0] lol_count,
    output logic                                all_good
);

    for (genvar i = 0; i < NUM_PLLS; i++) begin : g_chan
        pll_lock_channel #(
            .RESET_PULSE_CYCLES  (RESET_PULSE_CYCLES),
            .LOCK_TIMEOUT_CYCLES (LOCK_TIMEOUT_CYCLES),
            .LOCK_FILTER_CYCLES  (LOCK_FILTER_CYCLES),
            .RELEASE_DELAY_CYCLES(RELEASE_DELAY_CYCLES),
            .MAX_RETRIES         (MAX_RETRIES)
        ) u_chan (
            .clk        (clk),
            .rst        (rst),
            .enable     (pll_enable[i]),
            .lock_raw   (pll_lock_raw[i]),
            .fault_clear(fault_clear),
            .pll_rst    (pll_rst[i]),
            .pll_good   (pll_good[i]),
            .domain_rst (domain_rst[i]),
            .fault      (fault[i]),
            .lol_count  (lol_count[LOL_COUNT_WIDTH*i +: LOL_COUNT_WIDTH])
        );
    end

    // Disabled channels do not hold the bank down; an empty bank is never good
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            all_good <= 1'b0;
        end else begin
            all_good <= (|pll_enable) && (&(pll_good | ~pll_enable));
        end
    end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor: clean lock, glitch rejection,
// timeout/fault, loss-of-lock saturation, enable and reset override.
module tb_pll_lock_supervisor;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  pll_enable = 2'b00;
    logic [1:0]  pll_lock_raw = 2'b00;
    logic        fault_clear = 1'b0;
    logic [1:0]  pll_rst;
    logic [1:0]  pll_good;
    logic [1:0]  domain_rst;
    logic [1:0]  fault;
    logic [15:0] lol_count;
    logic        all_good;

    int errors = 0;
    int checks = 0;

    pll_lock_supervisor #(
        .NUM_PLLS            (2),
        .RESET_PULSE_CYCLES  (4),
        .LOCK_TIMEOUT_CYCLES (20),
        .LOCK_FILTER_CYCLES  (8),
        .RELEASE_DELAY_CYCLES(5),
        .MAX_RETRIES         (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pll_enable  (pll_enable),
        .pll_lock_raw(pll_lock_raw),
        .fault_clear (fault_clear),
        .pll_rst     (pll_rst),
        .pll_good    (pll_good),
        .domain_rst  (domain_rst),
        .fault       (fault),
        .lol_count   (lol_count),
        .all_good    (all_good)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_good(input int ch, input int limit);
        int n;
        n = 0;
        while (pll_good[ch] !== 1'b1 && n < limit) begin
            tick();
            n++;
        end
        chk("wait_good", 32'(pll_good[ch]), 32'd1);
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_pll_rst"}, 32'(pll_rst), 32'h3);
        chk({tag, "_domain_rst"}, 32'(domain_rst), 32'h3);
        chk({tag, "_pll_good"}, 32'(pll_good), 32'h0);
        chk({tag, "_fault"}, 32'(fault), 32'h0);
        chk({tag, "_lol"}, 32'(lol_count), 32'h0);
        chk({tag, "_all_good"}, 32'(all_good), 32'h0);
    endtask

    initial begin
        int falls;
        logic prev;

        // Power-on reset
        #3 rst = 1'b1;
        #1 chk_reset_values("por");
        tick(3);
        rst = 1'b0;
        tick(2);
        chk("idle_all_good", 32'(all_good), 32'd0);
        chk("idle_pll_rst", 32'(pll_rst), 32'h3);

        // Clean lock on ch0: enable in cycle 0, raw lock in cycle 10
        pll_enable[0] = 1'b1;
        tick();     chk("c1_pll_rst", 32'(pll_rst[0]), 32'd1);
        tick(3);    chk("c4_pll_rst", 32'(pll_rst[0]), 32'd1);
        tick();     chk("c5_pll_rst", 32'(pll_rst[0]), 32'd0);
        tick(5);    pll_lock_raw[0] = 1'b1;
        tick(9);    chk("c19_good", 32'(pll_good[0]), 32'd0);
        tick();     chk("c20_good", 32'(pll_good[0]), 32'd1);
                    chk("c20_domain", 32'(domain_rst[0]), 32'd1);
                    chk("c20_all_good", 32'(all_good), 32'd0);
        tick();     chk("c21_all_good", 32'(all_good), 32'd1);
        tick(3);    chk("c24_domain", 32'(domain_rst[0]), 32'd1);
        tick();     chk("c25_domain", 32'(domain_rst[0]), 32'd0);

        // Loss of lock: raw drops in cycle 0, outputs react in cycle 3
        pll_lock_raw[0] = 1'b0;
        tick(2);    chk("lol_c2_good", 32'(pll_good[0]), 32'd1);
        tick();     chk("lol_c3_good", 32'(pll_good[0]), 32'd0);
                    chk("lol_c3_domain", 32'(domain_rst[0]), 32'd1);
                    chk("lol_c3_pll_rst", 32'(pll_rst[0]), 32'd1);
                    chk("lol_c3_count", 32'(lol_count[7:0]), 32'd1);
        tick();     chk("lol_c4_all_good", 32'(all_good), 32'd0);

        // Glitch: 5 cycles of lock in WAIT_LOCK, then the timer restarts
        tick(4);    pll_lock_raw[0] = 1'b1;
        tick(5);    pll_lock_raw[0] = 1'b0;
        tick(2);    chk("glitch_good", 32'(pll_good[0]), 32'd0);
        tick(20);   chk("glitch_wait_rst", 32'(pll_rst[0]), 32'd0);
                    chk("glitch_wait_good", 32'(pll_good[0]), 32'd0);
        tick();     chk("glitch_retry_rst", 32'(pll_rst[0]), 32'd1);
                    chk("glitch_lol", 32'(lol_count[7:0]), 32'd1);
        pll_lock_raw[0] = 1'b1;
        wait_good(0, 40);

        // Repeated loss of lock saturates the counter
        for (int i = 1; i < 300; i++) begin
            pll_lock_raw[0] = 1'b0;
            tick();
            pll_lock_raw[0] = 1'b1;
            tick(2);
            wait_good(0, 40);
            if (i == 100) chk("lol_101", 32'(lol_count[7:0]), 32'd101);
        end
        chk("lol_sat", 32'(lol_count[7:0]), 32'd255);
        tick(6);
        chk("ch0_released", 32'(domain_rst[0]), 32'd0);

        // Timeout and fault on ch1, which never locks
        pll_enable[1] = 1'b1;
        falls = 0;
        prev = pll_rst[1];
        for (int c = 1; c <= 73; c++) begin
            tick();
            if (prev && !pll_rst[1]) falls++;
            prev = pll_rst[1];
            if (c == 72) chk("c72_fault", 32'(fault[1]), 32'd0);
        end
        chk("c73_fault", 32'(fault[1]), 32'd1);
        chk("c73_pll_rst", 32'(pll_rst[1]), 32'd1);
        chk("rst_pulses", 32'(falls), 32'd3);
        chk("fault_all_good", 32'(all_good), 32'd0);
        tick(3);
        chk("fault_held", 32'(fault[1]), 32'd1);
        chk("fault_rst_held", 32'(pll_rst[1]), 32'd1);
        fault_clear = 1'b1;
        tick();
        fault_clear = 1'b0;
        chk("clr_fault", 32'(fault[1]), 32'd0);
        chk("clr_pll_rst", 32'(pll_rst[1]), 32'd1);
        tick(3);    chk("clr_c4_pll_rst", 32'(pll_rst[1]), 32'd1);
        tick();     chk("clr_c5_pll_rst", 32'(pll_rst[1]), 32'd0);
        pll_enable[1] = 1'b0;
        tick(2);
        chk("ch1_off_all_good", 32'(all_good), 32'd1);
        chk("ch0_untouched", 32'(pll_good[0]), 32'd1);

        // Enable override during FILTER
        pll_lock_raw[0] = 1'b0;
        tick(3);    pll_lock_raw[0] = 1'b1;
        tick(7);    chk("filt_pll_rst", 32'(pll_rst[0]), 32'd0);
                    chk("filt_good", 32'(pll_good[0]), 32'd0);
        pll_enable[0] = 1'b0;
        tick();     chk("dis_pll_rst", 32'(pll_rst[0]), 32'd1);
                    chk("dis_good", 32'(pll_good[0]), 32'd0);
                    chk("dis_domain", 32'(domain_rst[0]), 32'd1);
                    chk("dis_lol_kept", 32'(lol_count[7:0]), 32'd255);
        tick();     chk("dis_all_good", 32'(all_good), 32'd0);

        // Relock, then asynchronous reset mid-cycle in GOOD
        pll_enable[0] = 1'b1;
        tick(2);
        wait_good(0, 40);
        tick(6);
        chk("relock_domain", 32'(domain_rst[0]), 32'd0);
        #3 rst = 1'b1;
        #1 chk_reset_values("async");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
